// File: rtl/run_ctrl.sv
// run_ctrl: run-control block for the paper processor.
// Decodes a HALT opcode, supports resume, single-step and counted stall,
// drives a registered core enable and counts enabled cycles (saturating).
// Optional clock gating is built when RUN_CTRL_CLKGATE_EN is defined;
// otherwise o_pulses is tied low and consumers use o_en as a synchronous enable.
//
// Handshake note: there is no valid/ready pairing here. i_instruct is only
// looked at when i_instr_valid is high; i_resume, i_step and i_stall_req are
// level-sampled on each rising edge and acted on only in the states that
// listen to them (no request is ever queued).
module run_ctrl #(
    parameter int                 INSTR_W   = 2,
    parameter logic [INSTR_W-1:0] HALT_CODE = 2'b10,
    parameter int                 STALL_W   = 4,
    parameter int                 CNT_W     = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [INSTR_W-1:0] i_instruct,
    input  logic               i_instr_valid,
    input  logic               i_resume,
    input  logic               i_step,
    input  logic               i_stall_req,
    input  logic [STALL_W-1:0] i_stall_len,
    output logic               o_en,
    output logic               o_pulses,
    output logic               o_halted,
    output logic               o_stalled,
    output logic [CNT_W-1:0]   o_run_cycles,
    output logic [1:0]         o_dbg_state
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_STEP  = 2'd2,
        ST_STALL = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [STALL_W-1:0] r_cnt;
    logic [STALL_W-1:0] w_next_cnt;
    logic               w_next_en;
    logic               r_en;
    logic               r_halted;
    logic               r_stalled;
    logic [CNT_W-1:0]   r_run_cycles;

    // Next-state and stall-counter logic; en is derived from the next state
    // so that it can be registered alongside the state.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            ST_RUN: begin
                // HALT opcode takes priority over a stall request.
                if (i_instr_valid && (i_instruct == HALT_CODE)) begin
                    w_next_state = ST_HALT;
                end else if (i_stall_req && (i_stall_len != '0)) begin
                    w_next_state = ST_STALL;
                    w_next_cnt   = i_stall_len;
                end
            end
            ST_HALT: begin
                if (i_resume) begin
                    w_next_state = ST_RUN;
                end else if (i_step) begin
                    w_next_state = ST_STEP;
                end
            end
            ST_STEP: begin
                w_next_state = ST_HALT;
            end
            ST_STALL: begin
                // Counter value 1 marks the last stalled cycle.
                if (r_cnt == STALL_W'(1)) begin
                    w_next_state = ST_RUN;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt = r_cnt - STALL_W'(1);
                end
            end
            default: begin
                w_next_state = ST_RUN;
                w_next_cnt   = '0;
            end
        endcase
        w_next_en = (w_next_state == ST_RUN) || (w_next_state == ST_STEP);
    end

    // State register with registered status outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= ST_RUN;
            r_cnt     <= '0;
            r_en      <= 1'b0;
            r_halted  <= 1'b0;
            r_stalled <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_cnt     <= w_next_cnt;
            r_en      <= w_next_en;
            r_halted  <= (w_next_state == ST_HALT);
            r_stalled <= (w_next_state == ST_STALL);
        end
    end

    // Saturating count of edges on which the core was enabled.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_run_cycles <= '0;
        end else if (r_en && (r_run_cycles != '1)) begin
            r_run_cycles <= r_run_cycles + CNT_W'(1);
        end
    end

`ifdef RUN_CTRL_CLKGATE_EN
    logic r_gate;

    // Enable latch, transparent while the clock is low, so the AND gate
    // below can only change during the low phase and never glitches.
    always_latch begin
        if (!i_clk) begin
            r_gate <= r_en;
        end
    end

    assign o_pulses = i_clk & r_gate;
`else
    assign o_pulses = 1'b0;
`endif

    assign o_en         = r_en;
    assign o_halted     = r_halted;
    assign o_stalled    = r_stalled;
    assign o_run_cycles = r_run_cycles;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed bench for run_ctrl. A second instance with a 4-bit
// cycle counter shares the inputs and is used for the saturation check.
module tb_run_ctrl;

    logic        clk;
    logic        reset;
    logic [1:0]  instruct;
    logic        instr_valid;
    logic        resume;
    logic        step;
    logic        stall_req;
    logic [3:0]  stall_len;

    logic        en, pulses, halted, stalled;
    logic [15:0] run_cycles;
    logic [1:0]  dbg_state;

    logic        en4, pulses4, halted4, stalled4;
    logic [3:0]  rc4;
    logic [1:0]  dbg4;

    int n_vec = 0;
    int n_err = 0;

    run_ctrl dut (
        .i_clk(clk), .i_reset(reset), .i_instruct(instruct),
        .i_instr_valid(instr_valid), .i_resume(resume), .i_step(step),
        .i_stall_req(stall_req), .i_stall_len(stall_len),
        .o_en(en), .o_pulses(pulses), .o_halted(halted), .o_stalled(stalled),
        .o_run_cycles(run_cycles), .o_dbg_state(dbg_state)
    );

    run_ctrl #(.CNT_W(4)) dut4 (
        .i_clk(clk), .i_reset(reset), .i_instruct(instruct),
        .i_instr_valid(instr_valid), .i_resume(resume), .i_step(step),
        .i_stall_req(stall_req), .i_stall_len(stall_len),
        .o_en(en4), .o_pulses(pulses4), .o_halted(halted4), .o_stalled(stalled4),
        .o_run_cycles(rc4), .o_dbg_state(dbg4)
    );

    // Clock and reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        instruct    = 2'b00;
        instr_valid = 1'b0;
        resume      = 1'b0;
        step        = 1'b0;
        stall_req   = 1'b0;
        stall_len   = 4'd0;
    endtask

    // Reset for one edge, then release for one edge: leaves en=1, run_cycles=0.
    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if ({en, halted, stalled} !== 3'b000 || run_cycles !== 16'd0) begin
                n_err++;
                $display("FAIL reset_hold[%0d]: en/halt/stall=%b rc=%0d, want 000 rc=0", i, {en, halted, stalled}, run_cycles);
            end
        end
        reset = 1'b0;
        tick();
        n_vec++;
        if ({en, halted, stalled} !== 3'b100 || run_cycles !== 16'd0 || dbg_state !== 2'd0) begin
            n_err++;
            $display("FAIL reset_release: en/halt/stall=%b rc=%0d st=%0d, want 100 rc=0 st=0", {en, halted, stalled}, run_cycles, dbg_state);
        end
        for (int i = 0; i < 5; i++) tick();
        n_vec++;
        if (run_cycles !== 16'd5 || en !== 1'b1) begin
            n_err++;
            $display("FAIL free_run: rc=%0d en=%b, want rc=5 en=1", run_cycles, en);
        end
    endtask

    task automatic test_halt_resume();
        do_reset();
        instr_valid = 1'b1;
        instruct    = 2'b10;
        tick();
        idle_inputs();
        n_vec++;
        if ({en, halted, stalled} !== 3'b010 || run_cycles !== 16'd1) begin
            n_err++;
            $display("FAIL halt_entry: en/halt/stall=%b rc=%0d, want 010 rc=1", {en, halted, stalled}, run_cycles);
        end
        // Non-halt opcode must not halt; but we're halted, so check it stays halted and frozen.
        instr_valid = 1'b1;
        instruct    = 2'b01;
        stall_req   = 1'b1;
        stall_len   = 4'd3;
        for (int i = 0; i < 4; i++) tick();
        idle_inputs();
        n_vec++;
        if ({en, halted, stalled} !== 3'b010 || run_cycles !== 16'd1) begin
            n_err++;
            $display("FAIL halt_frozen: en/halt/stall=%b rc=%0d, want 010 rc=1", {en, halted, stalled}, run_cycles);
        end
        resume = 1'b1;
        tick();
        resume = 1'b0;
        n_vec++;
        if ({en, halted, stalled} !== 3'b100 || run_cycles !== 16'd1) begin
            n_err++;
            $display("FAIL resume: en/halt/stall=%b rc=%0d, want 100 rc=1", {en, halted, stalled}, run_cycles);
        end
        tick();
        n_vec++;
        if (run_cycles !== 16'd2) begin
            n_err++;
            $display("FAIL resume_count: rc=%0d, want 2", run_cycles);
        end
        // A non-halt opcode in RUN keeps running.
        instr_valid = 1'b1;
        instruct    = 2'b11;
        tick();
        idle_inputs();
        n_vec++;
        if ({en, halted, stalled} !== 3'b100) begin
            n_err++;
            $display("FAIL non_halt_op: en/halt/stall=%b, want 100", {en, halted, stalled});
        end
    endtask

    task automatic test_step();
        do_reset();
        instr_valid = 1'b1;
        instruct    = 2'b10;
        tick();
        idle_inputs();
        resume = 1'b1;
        step   = 1'b1;
        tick();
        idle_inputs();
        n_vec++;
        if ({en, halted, stalled} !== 3'b100 || dbg_state !== 2'd0) begin
            n_err++;
            $display("FAIL resume_over_step: en/halt/stall=%b st=%0d, want 100 st=0", {en, halted, stalled}, dbg_state);
        end
        // rc: 1 after halt edge, 1 after resume edge
        instr_valid = 1'b1;
        instruct    = 2'b10;
        tick();
        idle_inputs();
        tick();
        n_vec++;
        if ({en, halted} !== 2'b01 || run_cycles !== 16'd2) begin
            n_err++;
            $display("FAIL rehalt: en/halt=%b rc=%0d, want 01 rc=2", {en, halted}, run_cycles);
        end
        step = 1'b1;
        tick();
        // Inputs during the step are ignored, including a HALT opcode and resume.
        step        = 1'b1;
        resume      = 1'b1;
        instr_valid = 1'b1;
        instruct    = 2'b10;
        n_vec++;
        if ({en, halted, stalled} !== 3'b100 || dbg_state !== 2'd2 || run_cycles !== 16'd2) begin
            n_err++;
            $display("FAIL step_cycle: en/halt/stall=%b st=%0d rc=%0d, want 100 st=2 rc=2", {en, halted, stalled}, dbg_state, run_cycles);
        end
        tick();
        idle_inputs();
        n_vec++;
        if ({en, halted, stalled} !== 3'b010 || run_cycles !== 16'd3) begin
            n_err++;
            $display("FAIL step_done: en/halt/stall=%b rc=%0d, want 010 rc=3", {en, halted, stalled}, run_cycles);
        end
        tick();
        n_vec++;
        if ({en, halted} !== 2'b01 || run_cycles !== 16'd3) begin
            n_err++;
            $display("FAIL step_once: en/halt=%b rc=%0d, want 01 rc=3", {en, halted}, run_cycles);
        end
    endtask

    task automatic test_stall();
        do_reset();
        stall_req = 1'b1;
        stall_len = 4'd4;
        tick();
        // Requests during the stall must be ignored.
        stall_len = 4'd7;
        resume    = 1'b1;
        step      = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if ({en, halted, stalled} !== 3'b001 || run_cycles !== 16'd1) begin
                n_err++;
                $display("FAIL stall_cycle[%0d]: en/halt/stall=%b rc=%0d, want 001 rc=1", i, {en, halted, stalled}, run_cycles);
            end
            if (i == 2) idle_inputs();
            if (i < 3) tick();
        end
        tick();
        n_vec++;
        if ({en, halted, stalled} !== 3'b100 || run_cycles !== 16'd1) begin
            n_err++;
            $display("FAIL stall_end: en/halt/stall=%b rc=%0d, want 100 rc=1", {en, halted, stalled}, run_cycles);
        end
        stall_req = 1'b1;
        stall_len = 4'd0;
        tick();
        idle_inputs();
        n_vec++;
        if ({en, halted, stalled} !== 3'b100 || run_cycles !== 16'd2) begin
            n_err++;
            $display("FAIL stall_len0: en/halt/stall=%b rc=%0d, want 100 rc=2", {en, halted, stalled}, run_cycles);
        end
        instr_valid = 1'b1;
        instruct    = 2'b10;
        stall_req   = 1'b1;
        stall_len   = 4'd5;
        tick();
        idle_inputs();
        n_vec++;
        if ({en, halted, stalled} !== 3'b010 || dbg_state !== 2'd1) begin
            n_err++;
            $display("FAIL halt_over_stall: en/halt/stall=%b st=%0d, want 010 st=1", {en, halted, stalled}, dbg_state);
        end
        // A stall of length 1 lasts exactly one cycle.
        resume = 1'b1;
        tick();
        idle_inputs();
        stall_req = 1'b1;
        stall_len = 4'd1;
        tick();
        idle_inputs();
        n_vec++;
        if ({en, stalled} !== 2'b01) begin
            n_err++;
            $display("FAIL stall1_in: en/stall=%b, want 01", {en, stalled});
        end
        tick();
        n_vec++;
        if ({en, stalled} !== 2'b10) begin
            n_err++;
            $display("FAIL stall1_out: en/stall=%b, want 10", {en, stalled});
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        stall_req = 1'b1;
        stall_len = 4'd15;
        tick();
        idle_inputs();
        for (int i = 0; i < 4; i++) tick();
        n_vec++;
        if ({en, stalled} !== 2'b01 || run_cycles !== 16'd1) begin
            n_err++;
            $display("FAIL long_stall: en/stall=%b rc=%0d, want 01 rc=1", {en, stalled}, run_cycles);
        end
        reset = 1'b1;
        tick();
        n_vec++;
        if ({en, halted, stalled} !== 3'b000 || run_cycles !== 16'd0 || dbg_state !== 2'd0 || pulses !== 1'b0) begin
            n_err++;
            $display("FAIL mid_stall_reset: en/halt/stall=%b rc=%0d st=%0d p=%b, want 000 rc=0 st=0 p=0", {en, halted, stalled}, run_cycles, dbg_state, pulses);
        end
        reset = 1'b0;
        tick();
        tick();
        n_vec++;
        if ({en, halted, stalled} !== 3'b100 || run_cycles !== 16'd1) begin
            n_err++;
            $display("FAIL after_stall_reset: en/halt/stall=%b rc=%0d, want 100 rc=1", {en, halted, stalled}, run_cycles);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) tick();
        n_vec++;
        if (rc4 !== 4'd15 || run_cycles !== 16'd20) begin
            n_err++;
            $display("FAIL saturate: rc4=%0d rc=%0d, want rc4=15 rc=20", rc4, run_cycles);
        end
    endtask

    task automatic test_gating();
        logic exp_p;
        do_reset();
        // Expected pulses in the high phase after an edge follow en as it was before that edge.
        for (int i = 0; i < 6; i++) begin
`ifdef RUN_CTRL_CLKGATE_EN
            exp_p = en;
`else
            exp_p = 1'b0;
`endif
            if (i == 2) begin
                instr_valid = 1'b1;
                instruct    = 2'b10;
            end
            if (i == 4) resume = 1'b1;
            tick();
            idle_inputs();
            n_vec++;
            if (pulses !== exp_p) begin
                n_err++;
                $display("FAIL pulses_high[%0d]: got %b want %b", i, pulses, exp_p);
            end
            @(negedge clk);
            #1;
            n_vec++;
            if (pulses !== 1'b0) begin
                n_err++;
                $display("FAIL pulses_low[%0d]: got %b want 0", i, pulses);
            end
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_halt_resume();
        test_step();
        test_stall();
        test_reset_mid_stall();
        test_saturation();
        test_gating();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
